mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported physical memory between the pipeline's two memory ports: port A (instruction fetch) and port B (data access). Both ports keep the processor's request/response convention. The block grants one request at a time using round-robin priority, forwards the granted port's request to memory, and routes the memory response back to that port only. It sits between the `mp3` core and a single-port memory, so the core itself is unchanged.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: number of cycles in a grant without `mem_resp` before `timeout_err` is set. 0 disables the check.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `read_a`, `write_a`  in  1 each  port A request strobes; held until `resp_a`.
- `wmask_a`  in  2  port A byte write mask.
- `address_a`, `wdata_a`  in  16 each  port A address and write data.
- `resp_a`  out  1  port A completion, one-cycle pulse.
- `rdata_a`  out  16  port A read data, valid while `resp_a` is high.
- `read_b`, `write_b`, `wmask_b`, `address_b`, `wdata_b`, `resp_b`, `rdata_b`: same as port A, for port B.
- `mem_read`, `mem_write`  out  1 each  downstream request strobes.
- `mem_wmask`  out  2  downstream byte mask.
- `mem_address`, `mem_wdata`  out  16 each  downstream address and write data.
- `mem_resp`  in  1  downstream completion pulse.
- `mem_rdata`  in  16  downstream read data.
- `timeout_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, SERVE_A, SERVE_B.
- A port requests when `read_x | write_x` is high. If a port drives both strobes, it is treated as a write and `mem_read` is forced to 0.
- IDLE transitions:
  - Only A requests: go to SERVE_A.
  - Only B requests: go to SERVE_B.
  - Both request: grant the port that was not granted last (`last_grant` register). Reset value of `last_grant` is B, so A wins the first tie.
  - Neither requests: stay in IDLE.
- While in SERVE_x:
  - `mem_*` outputs equal port x's inputs, combinationally.
  - `resp_x = mem_resp` and `rdata_x = mem_rdata`.
  - The other port sees `resp = 0` and `rdata = 0`.
- When `mem_resp` is high in SERVE_x: go to IDLE and set `last_grant` to x.
- Every grant is followed by exactly one IDLE cycle. A requester that holds its strobes high after `resp` is therefore never re-issued in the same cycle.
- In IDLE all `mem_*` outputs are 0, and so are `resp_a` and `resp_b`.
- If the granted port drops its request before `mem_resp`, this is a protocol violation. The block stays in SERVE_x and keeps waiting; no recovery is provided.
- Timeout:
  - A 10-bit cycle counter clears on entry to SERVE_x and saturates at `TIMEOUT_CYCLES`.
  - When the count reaches `TIMEOUT_CYCLES` with no `mem_resp`, set `timeout_err`. The grant is not released.

## Timing
- Reset values: state IDLE, `last_grant` B, counter 0, `timeout_err` 0. All `mem_*`, `resp_*` and `rdata_*` outputs are 0.
- Reset is asynchronous. If asserted in the middle of a grant, `mem_read` and `mem_write` drop to 0 in the same cycle.
- Added latency: the request is sampled in IDLE at cycle N, and `mem_*` asserts in cycle N+1. The response path is zero-cycle.
- Best case with back-to-back A and B requests and a memory that responds in 1 cycle:
  - cycle 1: A served;
  - cycle 2: IDLE;
  - cycle 3: B served.
  - Sustained throughput is one transfer per 2 cycles, plus memory latency.
- `mem_resp` arriving while in IDLE is ignored.

## Structure
- Package `lc3b_types` holds:
  - `lc3b_word` (16 bits) and `lc3b_mem_wmask` (2 bits);
  - `arb_state_t` enum {IDLE, SERVE_A, SERVE_B};
  - `arb_port_t` enum {PORT_A, PORT_B}.
- One combinational sub-module, `mem_port_mux`. It selects port A, port B or zero onto the `mem_*` outputs, using the state as select.
- The FSM, `last_grant` register and counter live in `mem_arbiter`.

## Test plan
- Reset with no requests: after deasserting `rst_n`, all outputs are 0 for 10 cycles.
- Single A read of `address_a=16'h0040`, memory returns 16'h1234 with 3-cycle latency: `mem_read` rises 1 cycle after `read_a`; `resp_a` pulses once with `rdata_a=16'h1234`; `resp_b` stays 0.
- A and B requesting in the same cycle from reset (A read 16'h0000, B write 16'h8000 with `wdata=16'hBEEF`, `wmask=2'b01`):
  - A is served first, then one IDLE cycle, then B.
  - `mem_wdata=16'hBEEF` and `mem_wmask=2'b01` during B's grant.
- Fairness: A and B both hold their requests high continuously for 8 transactions. Grants alternate A, B, A, B and every grant is separated by one IDLE cycle.
- Async reset mid-grant: assert `rst_n=0` during SERVE_B. `mem_write` drops to 0 in the same cycle. After release, a tied request grants A first.
- Timeout with `TIMEOUT_CYCLES=5`: memory never responds. `timeout_err` rises after the 5th cycle of the grant, stays high, and clears only on reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// lc3b_types: shared types for the memory arbiter slice.
//   lc3b_word / lc3b_mem_wmask : data and byte-mask widths of the core bus
//   arb_state_t                : arbiter FSM states
//   arb_port_t                 : identifies a requesting port
//   mem_req_t                  : one port's request bundle
//   drive_req()                : request as it should appear on the memory bus
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } arb_port_t;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
  } mem_req_t;

  localparam int unsigned CNT_W = 10;

  // A port driving both strobes is a write; read must not reach memory.
  function automatic mem_req_t drive_req(input mem_req_t r);
    mem_req_t d;
    d      = r;
    d.read = r.read & ~r.write;
    return d;
  endfunction

endpackage

// File: rtl/mem_arbiter_mem_port_mux.sv
// mem_port_mux: combinational steering between the two core ports and memory.
//   state            : arbiter state, used as the select
//   req_a, req_b     : port request bundles
//   mem_resp/rdata   : memory completion and read data
//   mem_req          : request presented to memory (zero when idle)
//   resp_x, rdata_x  : completion and data routed to the granted port only
module mem_port_mux
  import lc3b_types::*;
(
  input  arb_state_t state,
  input  mem_req_t   req_a,
  input  mem_req_t   req_b,
  input  logic       mem_resp,
  input  lc3b_word   mem_rdata,
  output mem_req_t   mem_req,
  output logic       resp_a,
  output logic       resp_b,
  output lc3b_word   rdata_a,
  output lc3b_word   rdata_b
);

  always_comb begin
    mem_req = '0;
    resp_a  = 1'b0;
    resp_b  = 1'b0;
    rdata_a = '0;
    rdata_b = '0;
    case (state)
      SERVE_A: begin
        mem_req = drive_req(req_a);
        resp_a  = mem_resp;
        rdata_a = mem_rdata;
      end
      SERVE_B: begin
        mem_req = drive_req(req_b);
        resp_b  = mem_resp;
        rdata_b = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory by two core ports.
//   clk, rst_n               : clock, async active-low reset
//   read_x/write_x/wmask_x/address_x/wdata_x : port x request (held until resp_x)
//   resp_x, rdata_x          : port x completion pulse and read data
//   mem_*                    : downstream memory request / response
//   timeout_err              : sticky, set when a grant waits TIMEOUT_CYCLES
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no grant; sample requests, pick next port
// SERVE_A | port A owns memory until mem_resp
// SERVE_B | port B owns memory until mem_resp
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read_a,
  input  logic          write_a,
  input  lc3b_mem_wmask wmask_a,
  input  lc3b_word      address_a,
  input  lc3b_word      wdata_a,
  output logic          resp_a,
  output lc3b_word      rdata_a,
  input  logic          read_b,
  input  logic          write_b,
  input  lc3b_mem_wmask wmask_b,
  input  lc3b_word      address_b,
  input  lc3b_word      wdata_b,
  output logic          resp_b,
  output lc3b_word      rdata_b,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_mem_wmask mem_wmask,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output logic          timeout_err
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t       state, state_nxt;
  arb_port_t        last_grant;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mem_req_t         req_a, req_b, mem_req;
  logic             want_a, want_b, serving;

  assign req_a   = {read_a, write_a, wmask_a, address_a, wdata_a};
  assign req_b   = {read_b, write_b, wmask_b, address_b, wdata_b};
  assign want_a  = read_a | write_a;
  assign want_b  = read_b | write_b;
  assign serving = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= PORT_B;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mem_resp && state == SERVE_A) last_grant <= PORT_A;
      if (mem_resp && state == SERVE_B) last_grant <= PORT_B;
      // Flag is raised on the edge where the count lands on the limit.
      if (TC != '0 && serving && !mem_resp && cnt_nxt == TC) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (want_a && want_b)
          state_nxt = (last_grant == PORT_B) ? SERVE_A : SERVE_B;
        else if (want_a)
          state_nxt = SERVE_A;
        else if (want_b)
          state_nxt = SERVE_B;
      end
      SERVE_A, SERVE_B: begin
        // A dropped request is not a release; only mem_resp ends the grant.
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter is held at 0 in IDLE, so it is already clear on grant entry.
  always_comb begin
    cnt_nxt = cnt;
    if (!serving)
      cnt_nxt = '0;
    else if (!mem_resp && cnt != TC)
      cnt_nxt = cnt + 1'b1;
  end

  mem_port_mux u_mux (
    .state    (state),
    .req_a    (req_a),
    .req_b    (req_b),
    .mem_resp (mem_resp),
    .mem_rdata(mem_rdata),
    .mem_req  (mem_req),
    .resp_a   (resp_a),
    .resp_b   (resp_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b)
  );

  assign mem_read    = mem_req.read;
  assign mem_write   = mem_req.write;
  assign mem_wmask   = mem_req.wmask;
  assign mem_address = mem_req.address;
  assign mem_wdata   = mem_req.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int T = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_a, write_a, read_b, write_b;
  logic [1:0]  wmask_a, wmask_b;
  logic [15:0] address_a, wdata_a, address_b, wdata_b;
  logic        resp_a, resp_b;
  logic [15:0] rdata_a, rdata_b;
  logic        mem_read, mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a),
    .address_a(address_a), .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b),
    .address_b(address_b), .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] phys    [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- physical memory model ----------------
  int mcnt = 0, cur_lat = 1, mem_lat = 0;
  bit spurious_en = 0;

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      mem_resp = 1'b0;
      mcnt     = 0;
    end else if (mem_resp) begin
      mem_resp  = 1'b0;
      mcnt      = 0;
      mem_rdata = 16'($urandom);
    end else if (mem_read || mem_write) begin
      if (mcnt == 0) cur_lat = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
      mcnt++;
      if (mcnt == cur_lat) begin
        mem_rdata = phys[mem_address];
        if (mem_write) begin
          if (mem_wmask[0]) phys[mem_address][7:0]  = mem_wdata[7:0];
          if (mem_wmask[1]) phys[mem_address][15:8] = mem_wdata[15:8];
        end
        mem_resp = 1'b1;
      end
    end else if (spurious_en && $urandom_range(0, 7) == 0) begin
      mem_resp = 1'b1;
    end
  end

  // ---------------- reference arbitration model ----------------
  // m_busy: 0 none, 1 port A, 2 port B; m_last: port served most recently.
  int          m_busy = 0, m_last = 2, m_cnt = 0, g;
  logic        m_err = 1'b0;
  logic        cur_wr, ra, rb;
  logic [1:0]  cur_m;
  logic [15:0] cur_addr, cur_d;
  logic [35:0] exp_bus;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_last = 2; m_cnt = 0; m_err = 1'b0;
      exp_a.delete(); exp_b.delete();
      check("reset_outputs", {mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
                              resp_a, resp_b, rdata_a, rdata_b, timeout_err}, 64'h0);
    end else begin
      exp_bus = '0;
      if (m_busy == 1) exp_bus = {read_a & ~write_a, write_a, wmask_a, address_a, wdata_a};
      if (m_busy == 2) exp_bus = {read_b & ~write_b, write_b, wmask_b, address_b, wdata_b};
      check("mem_bus", {mem_read, mem_write, mem_wmask, mem_address, mem_wdata}, exp_bus);
      check("resp_route_a", {resp_a, rdata_a}, (m_busy == 1) ? {mem_resp, mem_rdata} : 17'h0);
      check("resp_route_b", {resp_b, rdata_b}, (m_busy == 2) ? {mem_resp, mem_rdata} : 17'h0);
      check("timeout_err", timeout_err, m_err);

      ra = read_a | write_a;
      rb = read_b | write_b;
      if (m_busy == 0) begin
        if (ra && rb) g = (m_last == 1) ? 2 : 1;
        else if (ra)  g = 1;
        else if (rb)  g = 2;
        else          g = 0;
        if (g == 1) begin
          cur_wr = write_a; cur_addr = address_a; cur_d = wdata_a; cur_m = wmask_a;
          exp_a.push_back(ref_mem[address_a]);
        end else if (g == 2) begin
          cur_wr = write_b; cur_addr = address_b; cur_d = wdata_b; cur_m = wmask_b;
          exp_b.push_back(ref_mem[address_b]);
        end
        m_busy = g;
        m_cnt  = 0;
      end else if (mem_resp) begin
        if (cur_wr) begin
          if (cur_m[0]) ref_mem[cur_addr][7:0]  = cur_d[7:0];
          if (cur_m[1]) ref_mem[cur_addr][15:8] = cur_d[15:8];
        end
        m_last = m_busy;
        m_busy = 0;
      end else begin
        m_cnt++;
        if (m_cnt >= T) m_err = 1'b1;
      end
    end
  end

  // ---------------- response scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_a) begin
        check("resp_a_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) check("rdata_a", rdata_a, exp_a.pop_front());
      end
      if (resp_b) begin
        check("resp_b_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) check("rdata_b", rdata_b, exp_b.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input logic rd, input logic wr, input logic [1:0] m,
                          input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      read_a = rd; write_a = wr; wmask_a = m; address_a = a; wdata_a = d;
    end else begin
      read_b = rd; write_b = wr; wmask_b = m; address_b = a; wdata_b = d;
    end
  endtask

  // Entered just after a rising edge; returns just after the edge ending the resp cycle.
  task automatic wait_resp(input int p, output logic [15:0] rd);
    int n = 0;
    logic seen = 1'b0;
    rd = '0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = (p == 0) ? resp_a : resp_b;
      rd   = (p == 0) ? rdata_a : rdata_b;
    end
    check((p == 0) ? "resp_a_within_budget" : "resp_b_within_budget", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_port(input int p, input int n, input int max_gap);
    int          gap, kind;
    logic [15:0] a, rd;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        set_port(p, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (gap) begin @(posedge clk); #1; end
      end
      kind = $urandom_range(0, 2);
      a = ((p == 0) ? 16'h0040 : 16'h8000) + 16'($urandom_range(0, 7));
      set_port(p, kind != 1, kind != 0, 2'($urandom_range(0, 3)), a, 16'($urandom));
      wait_resp(p, rd);
    end
    set_port(p, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  logic [15:0] rd0, rd1;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      phys[i] = 16'h0; ref_mem[i] = 16'h0;
    end
    phys[16'h0040] = 16'h1234; ref_mem[16'h0040] = 16'h1234;
    phys[16'h8000] = 16'h5A5A; ref_mem[16'h8000] = 16'h5A5A;
    mem_resp = 1'b0; mem_rdata = 16'hA5A5;
    set_port(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
                             resp_a, resp_b, rdata_a, rdata_b, timeout_err}, 64'h0);
    end
    @(posedge clk); #1;

    // single A read, 3-cycle memory
    mem_lat = 3;
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0);
    @(negedge clk); check("read_not_yet_issued", mem_read, 1'b0);
    @(negedge clk); check("read_issued_next_cycle", {mem_read, mem_address}, {1'b1, 16'h0040});
    wait_resp(0, rd0);
    check("single_read_rdata", rd0, 16'h1234);
    set_port(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (2) begin @(posedge clk); #1; end

    // tie from reset: A first, then B write
    do_reset();
    mem_lat = 1;
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0);
    set_port(1, 1'b0, 1'b1, 2'b01, 16'h8000, 16'hBEEF);
    fork
      begin wait_resp(0, rd0); set_port(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0); end
      begin wait_resp(1, rd1); set_port(1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0); end
    join
    check("tie_b_write_merged", phys[16'h8000], 16'h5AEF);

    // fairness: both ports hold requests continuously
    mem_lat = 0;
    fork
      run_port(0, 8, 0);
      run_port(1, 8, 0);
    join

    // randomized traffic with spurious idle responses
    spurious_en = 1;
    fork
      run_port(0, 40, 3);
      run_port(1, 40, 3);
    join
    spurious_en = 0;
    repeat (3) begin @(posedge clk); #1; end

    // async reset during a B write grant
    mem_lat = 100000;
    set_port(1, 1'b0, 1'b1, 2'b11, 16'h8001, 16'h1111);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!mem_write && n < 20);
      check("b_write_granted", mem_write, 1'b1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("mem_strobes_drop_on_reset", {mem_read, mem_write}, 2'b00);
    mem_lat = 2;
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0042, 16'h0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk); check("post_reset_tie_grants_a", mem_address, 16'h0042);
    fork
      begin wait_resp(0, rd0); set_port(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0); end
      begin wait_resp(1, rd1); set_port(1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0); end
    join

    // timeout: memory never answers
    do_reset();
    mem_lat = 100000;
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0041, 16'h0);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("timeout_progress", timeout_err, (i >= T + 1) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("timeout_sticky", timeout_err, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("timeout_cleared_by_reset", timeout_err, 1'b0);
    mem_lat = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
